payload_rr_arbiter: RTL and testbench



---
 rtl/payload_rr_arbiter_if.sv | 43 ++++
 rtl/payload_rr_arbiter.sv | 166 ++++++++++++++++
 tb/tb_payload_rr_arbiter.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/payload_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// payload_rr_arbiter_if
// AXI4-Stream bundle carrying LANES independent streams packed side by side.
// Lane i occupies slice i of every vector field.
//   tdata  : LANES*DATA_WIDTH       payload
//   tstrb  : LANES*DATA_WIDTH/8     byte strobes
//   tuser  : LANES*USER_WIDTH       metadata
//   tvalid : LANES                  per-lane valid
//   tready : LANES                  per-lane ready (driven by the receiver)
//   tlast  : LANES                  per-lane end of packet
// Modports: master drives payload/valid/last and receives ready;
//           slave is the mirror image.
// ---------------------------------------------------------------------------
interface payload_rr_arbiter_if #(
    parameter int DATA_WIDTH = 256,
    parameter int USER_WIDTH = 128,
    parameter int LANES      = 1
);
    logic [LANES*DATA_WIDTH-1:0]   tdata;
    logic [LANES*DATA_WIDTH/8-1:0] tstrb;
    logic [LANES*USER_WIDTH-1:0]   tuser;
    logic [LANES-1:0]              tvalid;
    logic [LANES-1:0]              tready;
    logic [LANES-1:0]              tlast;

    modport master (
        output tdata,
        output tstrb,
        output tuser,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tstrb,
        input  tuser,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/payload_rr_arbiter.sv
// ---------------------------------------------------------------------------
// payload_rr_arbiter
// Packet-granular round-robin merge of NUM_QUEUES AXI4-Stream queues into a
// single stream. A packet is never interleaved with another: once a queue is
// granted it keeps the output until its tlast beat transfers. One idle cycle
// separates packets; beats pass through a combinational mux.
// Ports:
//   axi_aclk     clock
//   axi_aresetn  asynchronous active-low reset
//   s_axis       NUM_QUEUES-lane input bundle (slave side)
//   m_axis       single-lane output bundle toward payload_engine (master side)
//   enable       arbitration enable; an in-flight packet always completes
//   pkt_count    per-queue forwarded packet counters, CNT_WIDTH each, wrapping
//   cur_grant    index of the queue currently or last granted
// ---------------------------------------------------------------------------
module payload_rr_arbiter #(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int NUM_QUEUES         = 4,
    parameter int CNT_WIDTH          = 32
) (
    input  logic                             axi_aclk,
    input  logic                             axi_aresetn,
    payload_rr_arbiter_if.slave              s_axis,
    payload_rr_arbiter_if.master             m_axis,
    input  logic                             enable,
    output logic [NUM_QUEUES*CNT_WIDTH-1:0]  pkt_count,
    output logic [2:0]                       cur_grant
);

    localparam int DW = C_AXIS_DATA_WIDTH;
    localparam int SW = C_AXIS_DATA_WIDTH / 8;
    localparam int UW = C_AXIS_TUSER_WIDTH;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                state_r;
    state_t                state_nxt_s;
    logic [2:0]            grant_r;
    logic [2:0]            grant_nxt_s;
    logic [2:0]            last_grant_r;
    logic [CNT_WIDTH-1:0]  pkt_count_r [NUM_QUEUES];

    logic                  send_s;
    logic                  pkt_done_s;
    logic                  pick_found_s;
    logic [2:0]            pick_s;
    logic [3:0]            cand_s;
    logic                  hit_s;

    assign send_s     = (state_r == SEND);
    // The granted lane's last beat is accepted downstream.
    assign pkt_done_s = m_axis.tvalid[0] & m_axis.tready[0] & m_axis.tlast[0];

    // State, grant and last-grant registers.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_r      <= IDLE;
            grant_r      <= 3'd0;
            // Search starts after last_grant, so queue 0 wins first.
            last_grant_r <= 3'(NUM_QUEUES - 1);
        end else begin
            state_r <= state_nxt_s;
            grant_r <= grant_nxt_s;
            if (pkt_done_s) begin
                last_grant_r <= grant_r;
            end else begin
                last_grant_r <= last_grant_r;
            end
        end
    end

    // Per-queue packet counters; wrap naturally at 2^CNT_WIDTH.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            for (int q = 0; q < NUM_QUEUES; q++) begin
                pkt_count_r[q] <= '0;
            end
        end else begin
            for (int q = 0; q < NUM_QUEUES; q++) begin
                if (pkt_done_s && (grant_r == 3'(q))) begin
                    pkt_count_r[q] <= pkt_count_r[q] + CNT_WIDTH'(1);
                end else begin
                    pkt_count_r[q] <= pkt_count_r[q];
                end
            end
        end
    end

    // Round-robin search and next-state decision.
    always_comb begin
        state_nxt_s  = state_r;
        grant_nxt_s  = grant_r;
        pick_found_s = 1'b0;
        pick_s       = grant_r;
        cand_s       = 4'd0;
        hit_s        = 1'b0;
        // Visit last_grant+1 .. last_grant+NUM_QUEUES (mod NUM_QUEUES); the
        // final candidate is last_grant itself, so a lone requester re-wins.
        for (int i = 1; i <= NUM_QUEUES; i++) begin
            cand_s = {1'b0, last_grant_r} + 4'(i);
            cand_s = (cand_s >= 4'(NUM_QUEUES)) ? (cand_s - 4'(NUM_QUEUES)) : cand_s;
            for (int q = 0; q < NUM_QUEUES; q++) begin
                hit_s        = !pick_found_s && (cand_s == 4'(q)) && s_axis.tvalid[q];
                pick_s       = hit_s ? 3'(q) : pick_s;
                pick_found_s = pick_found_s | hit_s;
            end
        end
        case (state_r)
            IDLE: begin
                if (enable && pick_found_s) begin
                    state_nxt_s = SEND;
                    grant_nxt_s = pick_s;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SEND: begin
                // Grant is held through any tvalid gap until tlast transfers.
                if (pkt_done_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = SEND;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                grant_nxt_s = grant_r;
            end
        endcase
    end

    // Output mux of the granted lane; everything is zero outside SEND.
    always_comb begin
        m_axis.tdata  = '0;
        m_axis.tstrb  = '0;
        m_axis.tuser  = '0;
        m_axis.tvalid = '0;
        m_axis.tlast  = '0;
        s_axis.tready = '0;
        for (int q = 0; q < NUM_QUEUES; q++) begin
            if (send_s && (grant_r == 3'(q))) begin
                m_axis.tdata     = s_axis.tdata[q*DW +: DW];
                m_axis.tstrb     = s_axis.tstrb[q*SW +: SW];
                m_axis.tuser     = s_axis.tuser[q*UW +: UW];
                m_axis.tvalid[0] = s_axis.tvalid[q];
                m_axis.tlast[0]  = s_axis.tlast[q];
                s_axis.tready[q] = m_axis.tready[0];
            end else begin
                s_axis.tready[q] = 1'b0;
            end
        end
    end

    generate
        for (genvar g = 0; g < NUM_QUEUES; g++) begin : g_cnt
            assign pkt_count[g*CNT_WIDTH +: CNT_WIDTH] = pkt_count_r[g];
        end
    endgenerate

    assign cur_grant = grant_r;

endmodule

// File: tb/tb_payload_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_payload_rr_arbiter
// Randomized stimulus against a packet-level reference model. The model keeps
// an expected beat list per queue, which queue currently owns the output and
// where the round-robin pointer sits; it predicts grants with modulo search.
// ---------------------------------------------------------------------------
module tb_payload_rr_arbiter;
    localparam int DW = 32;
    localparam int UW = 8;
    localparam int SW = DW / 8;
    localparam int NQ = 4;
    localparam int CW = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           enable = 1'b0;
    logic [NQ*CW-1:0] pkt_count;
    logic [2:0]     cur_grant;

    payload_rr_arbiter_if #(.DATA_WIDTH(DW), .USER_WIDTH(UW), .LANES(NQ)) s_if ();
    payload_rr_arbiter_if #(.DATA_WIDTH(DW), .USER_WIDTH(UW), .LANES(1))  m_if ();

    payload_rr_arbiter #(
        .C_AXIS_DATA_WIDTH (DW),
        .C_AXIS_TUSER_WIDTH(UW),
        .NUM_QUEUES        (NQ),
        .CNT_WIDTH         (CW)
    ) dut (
        .axi_aclk   (clk),
        .axi_aresetn(rst_n),
        .s_axis     (s_if.slave),
        .m_axis     (m_if.master),
        .enable     (enable),
        .pkt_count  (pkt_count),
        .cur_grant  (cur_grant)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Stimulus sources (what the driver presents) and model expectations.
    logic [DW-1:0] src_d [NQ][$];
    bit            src_l [NQ][$];
    logic [DW-1:0] exp_d [NQ][$];
    bit            exp_l [NQ][$];

    logic [NQ-1:0] vld = '0;
    logic [NQ-1:0] acc = '0;
    bit            m_rdy = 1'b1;
    bit            gap_on = 1'b0;
    bit            rdy_rand = 1'b0;
    bit            en_rand = 1'b0;
    int            serial = 0;

    // Reference model state.
    bit busy;
    int owner;
    int last_g;
    int cnt [NQ];
    int order [$];

    function automatic logic [SW-1:0] strb_of(input logic [DW-1:0] d);
        return d[SW-1:0] ^ d[SW+3:4];
    endfunction

    function automatic logic [UW-1:0] user_of(input logic [DW-1:0] d);
        return d[UW-1:0] ^ 8'h5a;
    endfunction

    task automatic add_pkt(input int q, input int len);
        logic [DW-1:0] d;
        for (int b = 0; b < len; b++) begin
            d = {4'(q), 8'(serial), 4'(b), 16'($urandom)};
            src_d[q].push_back(d);
            src_l[q].push_back(b == len - 1);
            exp_d[q].push_back(d);
            exp_l[q].push_back(b == len - 1);
        end
        serial++;
    endtask

    task automatic model_reset();
        for (int q = 0; q < NQ; q++) begin
            src_d[q].delete();
            src_l[q].delete();
            exp_d[q].delete();
            exp_l[q].delete();
            cnt[q] = 0;
        end
        order.delete();
        busy   = 1'b0;
        owner  = 0;
        last_g = NQ - 1;
        acc    = '0;
    endtask

    // Apply accepted pops, then present the next beats and control inputs.
    task automatic drive();
        logic [NQ*DW-1:0] td;
        logic [NQ*SW-1:0] ts;
        logic [NQ*UW-1:0] tu;
        logic [NQ-1:0]    tl;
        bit hold;
        td = '0; ts = '0; tu = '0; tl = '0;
        for (int q = 0; q < NQ; q++) begin
            hold = vld[q] && !acc[q];
            if (acc[q]) begin
                void'(src_d[q].pop_front());
                void'(src_l[q].pop_front());
            end
            vld[q] = (src_d[q].size() > 0) && (hold || !gap_on || ($urandom_range(0, 3) != 0));
            if (vld[q]) begin
                td[q*DW +: DW] = src_d[q][0];
                ts[q*SW +: SW] = strb_of(src_d[q][0]);
                tu[q*UW +: UW] = user_of(src_d[q][0]);
                tl[q]          = src_l[q][0];
            end
        end
        acc = '0;
        s_if.tdata  = td;
        s_if.tstrb  = ts;
        s_if.tuser  = tu;
        s_if.tlast  = tl;
        s_if.tvalid = vld;
        m_rdy = rdy_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
        m_if.tready[0] = m_rdy;
        if (en_rand) enable = ($urandom_range(0, 7) != 0);
    endtask

    // Compare DUT outputs with the model, then advance the model one cycle.
    task automatic model_cycle();
        logic [NQ-1:0] et;
        bit ev;
        bit lst;
        et = '0;
        if (busy && m_rdy) et[owner] = 1'b1;
        ev = busy && vld[owner];
        check_eq("s_tready", s_if.tready, et);
        check_eq("m_tvalid", m_if.tvalid, ev);
        check_eq("cur_grant", cur_grant, owner);
        if (ev && exp_d[owner].size() > 0) begin
            check_eq("m_tdata", m_if.tdata, exp_d[owner][0]);
            check_eq("m_tstrb", m_if.tstrb, strb_of(exp_d[owner][0]));
            check_eq("m_tuser", m_if.tuser, user_of(exp_d[owner][0]));
            check_eq("m_tlast", m_if.tlast, exp_l[owner][0]);
        end else begin
            check_eq("m_tdata_idle", m_if.tdata, 0);
            check_eq("m_tlast_idle", m_if.tlast, 0);
        end
        for (int q = 0; q < NQ; q++) begin
            check_eq("pkt_count", pkt_count[q*CW +: CW], cnt[q] % (1 << CW));
        end
        if (busy) begin
            if (ev && m_rdy && exp_d[owner].size() > 0) begin
                acc[owner] = 1'b1;
                lst = exp_l[owner][0];
                void'(exp_d[owner].pop_front());
                void'(exp_l[owner].pop_front());
                if (lst) begin
                    cnt[owner]++;
                    last_g = owner;
                    busy = 1'b0;
                end
            end
        end else if (enable && (vld != '0)) begin
            for (int k = 1; k <= NQ; k++) begin
                if (!busy && vld[(last_g + k) % NQ]) begin
                    owner = (last_g + k) % NQ;
                    busy  = 1'b1;
                    order.push_back(owner);
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
        drive();
    endtask

    function automatic bit sources_empty();
        for (int q = 0; q < NQ; q++) begin
            if (src_d[q].size() > 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((busy || !sources_empty()) && n < budget) begin
            step();
            n++;
        end
        check_eq("drain_timeout", (n >= budget), 0);
    endtask

    initial begin
        int base;
        s_if.tdata = '0; s_if.tstrb = '0; s_if.tuser = '0;
        s_if.tvalid = '0; s_if.tlast = '0;
        m_if.tready = 1'b1;
        model_reset();

        // Fairness: all queues loaded with five 3-beat packets before reset release.
        for (int p = 0; p < 5; p++) begin
            for (int q = 0; q < NQ; q++) add_pkt(q, 3);
        end
        enable = 1'b1;
        drive();
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_tvalid", m_if.tvalid, 0);
        check_eq("reset_tready", s_if.tready, 0);
        rst_n = 1'b1;
        drain(400);
        check_eq("fair_npkts", order.size(), 20);
        for (int k = 0; k < 20 && k < order.size(); k++) begin
            check_eq("fair_order", order[k], k % NQ);
        end
        for (int q = 0; q < NQ; q++) begin
            check_eq("fair_count", pkt_count[q*CW +: CW], 5);
        end

        // Random traffic with gaps, backpressure and enable drops.
        gap_on = 1'b1; rdy_rand = 1'b1; en_rand = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                int q;
                q = $urandom_range(0, NQ - 1);
                if (src_d[q].size() < 12) add_pkt(q, $urandom_range(1, 5));
            end
            step();
        end
        en_rand = 1'b0; enable = 1'b1;
        drain(3000);

        // Only queues 1 and 3 request; the others must never be granted.
        base = order.size();
        for (int p = 0; p < 3; p++) begin
            add_pkt(1, $urandom_range(1, 4));
            add_pkt(3, $urandom_range(1, 4));
        end
        drain(1000);
        for (int k = base; k < order.size(); k++) begin
            check_eq("skip_order", (order[k] == 1 || order[k] == 3), 1);
        end

        // Reset in the middle of a packet clears outputs asynchronously.
        gap_on = 1'b0; rdy_rand = 1'b0;
        add_pkt(0, 6);
        add_pkt(2, 6);
        repeat (4) step();
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_tvalid", m_if.tvalid, 0);
        check_eq("rst_mid_tdata", m_if.tdata, 0);
        check_eq("rst_mid_tlast", m_if.tlast, 0);
        check_eq("rst_mid_tready", s_if.tready, 0);
        check_eq("rst_mid_grant", cur_grant, 0);
        check_eq("rst_mid_count", pkt_count, 0);
        model_reset();
        drive();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Counter wrap: 17 packets from queue 0 leave 1 in a 4-bit counter.
        for (int p = 0; p < 17; p++) add_pkt(0, $urandom_range(1, 2));
        drain(500);
        check_eq("wrap_count", pkt_count[CW-1:0], 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time limit so the bench always ends.
    initial begin
        #2000000;
        $display("FAIL global_timeout got=%0d exp=finished", checks);
        $fatal(1, "timeout");
    end

endmodule
